bt_uart_rx: RTL
===============

BT_UART_RX -- requirements
Module: bt_uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10417, meaning clock cycles per serial bit (100 MHz / 9600 baud); legal range 4..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter SYNC_STAGES, default 3, meaning input synchroniser depth; legal range 2..4.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port get, input, 1 bit: serial line, idle high, LSB-first 8N1-style framing.
REQ-007 SHALL have port data, output, DATA_BITS wide: last accepted word.
REQ-008 SHALL have port data_valid, output, 1 bit: data holds an unconsumed word.
REQ-009 SHALL have port data_ack, input, 1 bit: consumer takes the word.
REQ-010 SHALL have port busy, output, 1 bit: a frame is in progress (state is not IDLE).
REQ-011 SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit samples low.
REQ-012 SHALL have port overrun, output, 1 bit: sticky flag, set when a good frame completes while data_valid=1.
REQ-013 SHALL have port parity_err, output, 1 bit: one-cycle pulse; present only when UART_RX_PARITY_EN is defined.

Function
REQ-014 SHALL pass get through SYNC_STAGES flops, each reset to 1, and detect a start edge as synchronised previous=1 and current=0.
REQ-015 SHALL implement the state machine IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, with the bit counter reset to 0 on every state entry.
REQ-016 SHALL enter START on a start edge, and only from IDLE.
REQ-017 SHALL sample the synchronised line when the bit counter = CLKS_PER_BIT/2-1, using integer division.
REQ-018 SHALL treat a START-state sample of 1 as a false start: return to IDLE, with no flag and no output change.
REQ-019 SHALL, in DATA, shift sample k into bit k of the shift register (LSB first), leaving DATA after DATA_BITS full bit periods.
REQ-020 SHALL, in STOP, act at the mid-bit sample:
- sample 1 -> write shift register to data, set data_valid, return to IDLE immediately (half-bit early, so back-to-back frames are caught).
- sample 0 -> pulse frame_err, discard the word, stay in STOP until the line reads 1, then go to IDLE.
REQ-021 SHALL clear data_valid on the cycle after data_ack=1 while data_valid=1; data_ack while data_valid=0 has no effect.
REQ-022 SHALL give priority to the new word when a word completes in the same cycle as data_ack: data updates and data_valid stays 1.
REQ-023 SHALL, when a good frame completes while data_valid=1 and data_ack=0, overwrite data with the new word and set overrun; overrun is cleared only by rst.
REQ-024 SHALL make a word visible on data/data_valid exactly 1 cycle after the stop-bit mid-sample.
REQ-025 SHALL size the bit counter to $clog2(CLKS_PER_BIT) bits; it never exceeds CLKS_PER_BIT-1.

Reset
REQ-026 SHALL, on rst=1 (asynchronous, at any point including mid-frame), set: state IDLE, counters 0, synchroniser flops 1, data 0, data_valid 0, busy 0, frame_err 0, overrun 0, parity_err 0.
REQ-027 SHALL, after rst deasserts, start a new frame only on a fresh falling edge; a line already low at deassertion is not a start edge.

Configuration
REQ-028 SHALL, with UART_RX_PARITY_EN defined, include a PARITY state between DATA and STOP that checks even parity over data plus the parity bit.
- On mismatch: pulse parity_err and discard the word; STOP is still checked.
- Without the macro: there is no PARITY state and no parity_err port, and the frame is start + DATA_BITS + stop.

Structure
REQ-029 SHALL place the state enum (IDLE/START/DATA/PARITY/STOP) and the default-parameter constants in shared package bt_uart_pkg.
REQ-030 SHALL place the bit-period counter in sub-module bt_uart_baud_cnt, which provides a mid-bit strobe and an end-of-bit strobe and is cleared on state change.

Verification (CLKS_PER_BIT=16, DATA_BITS=8)
REQ-031 SHALL check: frame 0x35, ack held low -> data=0x35 and data_valid=1 at 1 cycle after the stop mid-sample; frame_err=0.
REQ-032 SHALL check: 4-cycle low glitch on get -> false start, back to IDLE, data_valid stays 0.
REQ-033 SHALL check: frame 0xA5 with stop bit forced 0 -> one frame_err pulse, data unchanged, IDLE only after the line returns high.
REQ-034 SHALL check: frames 0x11 then 0x22 back-to-back, no ack -> data=0x22 and overrun=1; a later data_ack clears data_valid but not overrun.
REQ-035 SHALL check: rst pulsed during DATA bit 3 -> all outputs 0 immediately; a following 0x5A frame is received correctly.
REQ-036 SHALL check, with UART_RX_PARITY_EN: frame 0x07 with parity bit 0 -> parity_err pulse, data_valid stays 0.

Source files
------------

// File: rtl/bt_uart_pkg.sv
// Shared definitions for the bt_uart receiver: FSM state encoding and the
// default parameter values used by bt_uart_rx and bt_uart_baud_cnt.
package bt_uart_pkg;

    // 100 MHz clock, 9600 baud
    localparam int DEF_CLKS_PER_BIT = 10417;
    localparam int DEF_DATA_BITS    = 8;
    localparam int DEF_SYNC_STAGES  = 3;

    // Receiver frame states; PARITY is only visited in parity-enabled builds.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/bt_uart_baud_cnt.sv
// Bit-period counter for the UART receiver. Counts 0..CLKS_PER_BIT-1 and
// wraps. It raises mid_tick in the mid-bit count (CLKS_PER_BIT/2-1) and
// end_tick in the last count of the bit. clear holds the count at 0; the
// receiver asserts it on every state change so that each state starts its
// bit timing from zero.
module bt_uart_baud_cnt
    import bt_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic mid_tick,
    output logic end_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] MID_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] END_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign mid_tick = (cnt_q == MID_CNT);
    assign end_tick = (cnt_q == END_CNT);

    // Next count: zero on clear or at end of bit, otherwise increment.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || end_tick) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bt_uart_rx.sv
// UART receiver: idle-high line, LSB-first, start + DATA_BITS [+ parity] + stop.
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit
// between the data and stop bits and the parity_err output.
//
// Output handshake: data_valid rises one cycle after the stop-bit mid-sample
// of a good frame and stays high until the consumer pulses data_ack while
// data_valid=1; data_valid then drops on the following cycle. A new good word
// always wins over a same-cycle ack. A good word arriving while data_valid=1
// and data_ack=0 overwrites data and sets the sticky overrun flag.
module bt_uart_rx
    import bt_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 get,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ack,
    output logic                 busy,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 overrun
);

    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
    localparam uart_state_e AFTER_DATA = PARITY;
`else
    localparam uart_state_e AFTER_DATA = STOP;
`endif

    // Synchroniser and start-edge detection
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   line_prev_q;
    logic                   line_prev_d;
    // Fills with ones after reset; edges are only trusted once every stage
    // (and line_prev) holds a real line sample rather than its reset value.
    logic [SYNC_STAGES:0]   fill_q;
    logic [SYNC_STAGES:0]   fill_d;
    logic                   rx_line;
    logic                   armed;
    logic                   start_edge;

    assign rx_line     = sync_q[SYNC_STAGES-1];
    assign armed       = fill_q[SYNC_STAGES];
    assign start_edge  = armed && line_prev_q && !rx_line;

    // Shift the raw line through the synchroniser and track fill after reset.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], get};
        line_prev_d = rx_line;
        fill_d      = {fill_q[SYNC_STAGES-1:0], 1'b1};
    end

    // Synchroniser registers; stages reset high to match an idle line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '1;
            line_prev_q <= 1'b1;
            fill_q      <= '0;
        end else begin
            sync_q      <= sync_d;
            line_prev_q <= line_prev_d;
            fill_q      <= fill_d;
        end
    end

    // Frame FSM and datapath
    uart_state_e            state_q;
    uart_state_e            state_d;
    logic [BIT_W-1:0]       bit_idx_q;
    logic [BIT_W-1:0]       bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   shift_d;
    logic [DATA_BITS-1:0]   data_q;
    logic [DATA_BITS-1:0]   data_d;
    logic                   valid_q;
    logic                   valid_d;
    logic                   overrun_q;
    logic                   overrun_d;
    logic                   frame_err_q;
    logic                   frame_err_d;
    logic                   stop_bad_q;
    logic                   stop_bad_d;
    logic                   word_ok;
    logic                   mid_tick;
    logic                   end_tick;
    logic                   cnt_clear;

`ifdef UART_RX_PARITY_EN
    logic                   par_bad_q;
    logic                   par_bad_d;
    logic                   parity_err_q;
    logic                   parity_err_d;

    assign word_ok    = !par_bad_q;
    assign parity_err = parity_err_q;
`else
    assign word_ok    = 1'b1;
`endif

    // Bit timing restarts at zero on every state entry and is parked in IDLE.
    assign cnt_clear = (state_d != state_q) || (state_q == IDLE);

    bt_uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .mid_tick (mid_tick),
        .end_tick (end_tick)
    );

    // Next-state, data capture, handshake and flag logic.
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        frame_err_d = 1'b0;
        stop_bad_d  = stop_bad_q;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif

        if (valid_q && data_ack) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                stop_bad_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                par_bad_d  = 1'b0;
`endif
                if (start_edge) begin
                    state_d = START;
                end
            end

            START: begin
                // A high line at mid start bit was noise: drop it silently.
                if (mid_tick && rx_line) begin
                    state_d = IDLE;
                end else if (end_tick) begin
                    state_d = DATA;
                end
            end

            DATA: begin
                // LSB arrives first, so after DATA_BITS shifts it sits in bit 0.
                if (mid_tick) begin
                    shift_d = {rx_line, shift_q[DATA_BITS-1:1]};
                end
                if (end_tick) begin
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = AFTER_DATA;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                // Even parity: data bits plus parity bit must XOR to zero.
                if (mid_tick && (^{shift_q, rx_line})) begin
                    parity_err_d = 1'b1;
                    par_bad_d    = 1'b1;
                end
                if (end_tick) begin
                    state_d = STOP;
                end
            end
`endif

            STOP: begin
                if (stop_bad_q) begin
                    // Broken stop bit: wait for the line to recover.
                    if (rx_line) begin
                        state_d = IDLE;
                    end
                end else if (mid_tick) begin
                    if (rx_line) begin
                        // Leave half a bit early so a back-to-back start is seen.
                        state_d = IDLE;
                        if (word_ok) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            if (valid_q && !data_ack) begin
                                overrun_d = 1'b1;
                            end
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        stop_bad_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            bit_idx_d = '0;
        end
    end

    // Frame FSM and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            stop_bad_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            stop_bad_q  <= stop_bad_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end
`endif

    assign data       = data_q;
    assign data_valid = valid_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule
